calc_core_param: RTL and testbench
==================================

Name: calc_core_param

Overview:
Parametrised next-generation calculator core: WIDTH-bit operand/opcode/result registers plus an ALU with nine operations. Single-cycle logic ops; iterative multiply/divide take WIDTH cycles and use a busy/done handshake. Adds double-width results, carry/overflow/div-by-zero flags and result-to-A chaining. Sits between the user-input front end and the display/readback logic.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 4..32.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
user_input  in  WIDTH  operand data
load_a  in  1  A <= user_input (idle only)
load_b  in  1  B <= user_input (idle only)
load_a_from_result  in  1  A <= result (idle only); load_a has priority
user_opcode  in  4  operation code
load_opcode  in  1  OpcodeReg <= user_opcode (idle only)
execute  in  1  start operation (idle only)
busy  out  1  high while a multi-cycle op runs
done  out  1  one-cycle pulse when result/flags update
result  out  WIDTH  low half of result
result_hi  out  WIDTH  product high half / remainder; 0 for other ops
zero_flag  out  1  result == 0
carry_flag  out  1  carry/borrow/shifted-out bit
overflow_flag  out  1  signed overflow (ADD/SUB); product high half nonzero (MUL)
div_zero_flag  out  1  DIV with B == 0

Behaviour:
- Reset (sync, rst=1 at edge): A, B, OpcodeReg, result, result_hi, all flags, busy, done <= 0; state <= IDLE. Reset mid-operation aborts; no done pulse.
- States: IDLE, RUN. Only IDLE honours loads and execute; in RUN all load_*/execute are ignored.
- Execute in IDLE uses register values before that edge; simultaneous loads at the same edge take effect but do not affect that op.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL, 8 DIV, 9..15 undefined.
- Single-cycle ops (0..6, undefined, DIV with B==0): result/flags written at execute edge N; done=1 during cycle N..N+1 only; busy stays 0.
- MUL/DIV (B!=0): edge N: state<=RUN, busy<=1, counter<=0. Each RUN edge performs one shift-add (MUL, unsigned) or one restoring-divide step (DIV, unsigned). Edge N+WIDTH: result/result_hi/flags written, done<=1, busy<=0, state<=IDLE. A new execute is accepted at edge N+WIDTH+1 at the earliest.
- ADD: carry = carry-out; overflow = signed overflow. SUB (A-B): carry = borrow (A<B unsigned); overflow = signed overflow.
- AND/OR/XOR: carry=0, overflow=0.
- SHL/SHR: shift A by B mod WIDTH, zero fill. Carry = last bit shifted out; 0 if amount 0. Overflow 0.
- MUL: {result_hi,result} = A*B; overflow = (result_hi != 0); carry 0.
- DIV: result = A/B, result_hi = A%B. B==0: result = all ones, result_hi = A, div_zero_flag=1, single cycle.
- div_zero_flag is cleared by any other completed op.
- Undefined opcode: result=0, result_hi=0, zero_flag=1, other flags 0.
- zero_flag always reflects the low-half result only.
- Flags and results hold until next completion or reset.

Decomposition:
- Package calc_pkg: opcode_e (4-bit enum, values above), state_e {IDLE, RUN}, OPC_W=4.
- Sub-module calc_muldiv_unit (WIDTH param): start, is_div, a, b in; busy, done, lo, hi out. Iterative shift-add/restoring divide with $clog2(WIDTH)+1 counter.
- Single-cycle ops stay inline in calc_core_param.

Test Plan:
- WIDTH=8, A=200, B=100, ADD -> result 0x2C, carry=1, overflow=0, zero=0; done high exactly the cycle after execute; busy never 1.
- SUB 5-5 -> result 0, zero=1, carry=0. Then SUB 3-5 -> 0xFE, carry=1. Then A=0x7F, B=0xFF, SUB -> 0x80, overflow=1.
- MUL 25*20 -> busy high 8 cycles; at edge N+8 result=0xF4, result_hi=0x01, overflow=1, done single pulse.
- DIV 100/7 -> result 14, result_hi 2 after 8 cycles. Mid-run, load_a=0xFF and execute pulses are ignored: A still 100, no second op.
- DIV 100/0 -> one cycle: result 0xFF, result_hi 100, div_zero=1. Next ADD 1+1 -> 2, div_zero=0.
- MUL started, rst at 3rd RUN cycle -> all outputs 0, busy 0, no done. Then load 6, 7, MUL -> 42; then load_a_from_result, load_b=2, ADD -> 44.

Source files
------------

// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared types for the calculator core: opcode encoding, controller states and
// the opcode width. Imported by calc_muldiv_unit and calc_core_param.
// -----------------------------------------------------------------------------
package calc_pkg;

    localparam int OPC_W = 4;

    // Codes 9..15 are undefined; the core treats them as "result 0".
    typedef enum logic [OPC_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SHL = 4'd5,
        OP_SHR = 4'd6,
        OP_MUL = 4'd7,
        OP_DIV = 4'd8
    } opcode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/calc_muldiv_unit.sv
// -----------------------------------------------------------------------------
// calc_muldiv_unit
// Iterative unsigned multiplier (shift-add) / divider (restoring), one step per
// clock, WIDTH steps per operation.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start_i    begin an operation (ignored while busy)
//   is_div_i   1 = divide a_i / b_i, 0 = multiply a_i * b_i
//   a_i, b_i   operands, sampled on the start edge
//   busy_o     high while steps remain
//   done_o     high in the cycle whose closing edge performs the final step
//   lo_o, hi_o value the registers take at the next edge; when done_o is high
//              this is the finished answer (product lo/hi or quotient/remainder)
// -----------------------------------------------------------------------------
module calc_muldiv_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic             busy_q;
    logic             is_div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] b_q;
    // lo_q: multiplier bits being consumed (MUL) or dividend/quotient (DIV).
    // hi_q: partial product high half (MUL) or partial remainder (DIV).
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic             ge;

    always_comb begin
        // MUL: conditionally add the multiplicand, then shift {sum, lo} right.
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        // DIV: bring down the next dividend bit and trial-subtract the divisor.
        shifted = {hi_q, lo_q[WIDTH-1]};
        ge      = (shifted >= {1'b0, b_q});
        if (is_div_q) begin
            hi_d = ge ? (shifted[WIDTH-1:0] - b_q) : shifted[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], ge};
        end else begin
            hi_d = sum[WIDTH:1];
            lo_d = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
            b_q      <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
        end else if (start_i && !busy_q) begin
            busy_q   <= 1'b1;
            is_div_q <= is_div_i;
            cnt_q    <= '0;
            b_q      <= b_i;
            lo_q     <= a_i;
            hi_q     <= '0;
        end else if (busy_q) begin
            lo_q  <= lo_d;
            hi_q  <= hi_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == LAST_STEP);
    assign lo_o   = lo_d;
    assign hi_o   = hi_d;

endmodule

// File: rtl/calc_core_param.sv
// -----------------------------------------------------------------------------
// calc_core_param
// Calculator core: operand A/B and opcode registers, single-cycle ALU for
// ADD/SUB/AND/OR/XOR/SHL/SHR (and DIV by zero), iterative MUL/DIV through
// calc_muldiv_unit, registered result/result_hi and flags.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   user_input               operand data for load_a / load_b
//   load_a, load_b           load A / B from user_input (idle only)
//   load_a_from_result       A <= result (idle only, load_a wins)
//   user_opcode, load_opcode opcode register load (idle only)
//   execute                  start the operation held in the registers
//   busy                     multi-cycle operation in progress
//   done                     one-cycle pulse when result/flags update
//   result, result_hi        low half; high half of product or remainder
//   zero/carry/overflow/div_zero_flag   status of the last completed op
// -----------------------------------------------------------------------------
module calc_core_param
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] user_input,
    input  logic             load_a,
    input  logic             load_b,
    input  logic             load_a_from_result,
    input  logic [OPC_W-1:0] user_opcode,
    input  logic             load_opcode,
    input  logic             execute,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             overflow_flag,
    output logic             div_zero_flag
);

    localparam int SH_W = $clog2(WIDTH);

    state_e           state_q;
    opcode_e          opcode_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] result_q, result_hi_q;
    logic             zero_q, carry_q, ovf_q, dz_q, done_q;

    logic [WIDTH-1:0] alu_res, alu_hi;
    logic             alu_c, alu_v, alu_dz;
    logic [WIDTH:0]   add_w, sub_w, shl_w, shr_w;
    logic [SH_W-1:0]  shamt;

    logic             start_multi, mdu_start, mdu_busy, mdu_done;
    logic [WIDTH-1:0] mdu_lo, mdu_hi;

    // DIV by zero resolves in one cycle, so only a real divide goes iterative.
    assign start_multi = (opcode_q == OP_MUL) || ((opcode_q == OP_DIV) && (b_q != '0));
    assign mdu_start   = (state_q == IDLE) && execute && start_multi;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        alu_res = '0;
        alu_hi  = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_dz  = 1'b0;
        shamt   = SH_W'(32'(b_q) % 32'(WIDTH));
        add_w   = {1'b0, a_q} + {1'b0, b_q};
        sub_w   = {1'b0, a_q} - {1'b0, b_q};
        // One spare bit on the far side of each shift catches the last bit
        // shifted out; it stays 0 for a zero shift amount.
        shl_w   = {1'b0, a_q} << shamt;
        shr_w   = {a_q, 1'b0} >> shamt;
        case (opcode_q)
            OP_ADD: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = sub_w[WIDTH];
                alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_SHL: begin
                alu_res = shl_w[WIDTH-1:0];
                alu_c   = shl_w[WIDTH];
            end
            OP_SHR: begin
                alu_res = shr_w[WIDTH:1];
                alu_c   = shr_w[0];
            end
            OP_DIV: begin
                alu_res = '1;
                alu_hi  = a_q;
                alu_dz  = 1'b1;
            end
            default: ;
        endcase
    end

    calc_muldiv_unit #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start_i  (mdu_start),
        .is_div_i (opcode_q == OP_DIV),
        .a_i      (a_q),
        .b_i      (b_q),
        .busy_o   (mdu_busy),
        .done_o   (mdu_done),
        .lo_o     (mdu_lo),
        .hi_o     (mdu_hi)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            opcode_q    <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_a) begin
                        a_q <= user_input;
                    end else if (load_a_from_result) begin
                        a_q <= result_q;
                    end
                    if (load_b)      b_q      <= user_input;
                    if (load_opcode) opcode_q <= opcode_e'(user_opcode);
                    if (execute) begin
                        if (start_multi) begin
                            state_q <= RUN;
                        end else begin
                            result_q    <= alu_res;
                            result_hi_q <= alu_hi;
                            zero_q      <= (alu_res == '0);
                            carry_q     <= alu_c;
                            ovf_q       <= alu_v;
                            dz_q        <= alu_dz;
                            done_q      <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (mdu_done) begin
                        result_q    <= mdu_lo;
                        result_hi_q <= mdu_hi;
                        zero_q      <= (mdu_lo == '0);
                        carry_q     <= 1'b0;
                        ovf_q       <= (opcode_q == OP_MUL) && (mdu_hi != '0);
                        dz_q        <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy          = mdu_busy;
    assign done          = done_q;
    assign result        = result_q;
    assign result_hi     = result_hi_q;
    assign zero_flag     = zero_q;
    assign carry_flag    = carry_q;
    assign overflow_flag = ovf_q;
    assign div_zero_flag = dz_q;

endmodule

// File: tb/tb_calc_core_param.sv
// -----------------------------------------------------------------------------
// tb_calc_core_param
// Scoreboard bench for calc_core_param (WIDTH=8). Each execute pushes the
// reference answer into a queue; a negedge monitor pops and compares whenever
// done is high. The reference model uses plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_calc_core_param;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] user_input = '0;
    logic         load_a = 1'b0, load_b = 1'b0, load_a_from_result = 1'b0;
    logic [3:0]   user_opcode = '0;
    logic         load_opcode = 1'b0, execute = 1'b0;
    logic         busy, done, zero_flag, carry_flag, overflow_flag, div_zero_flag;
    logic [W-1:0] result, result_hi;

    always #5 clk = ~clk;

    calc_core_param #(.WIDTH(W)) dut (
        .clk                (clk),
        .rst                (rst),
        .user_input         (user_input),
        .load_a             (load_a),
        .load_b             (load_b),
        .load_a_from_result (load_a_from_result),
        .user_opcode        (user_opcode),
        .load_opcode        (load_opcode),
        .execute            (execute),
        .busy               (busy),
        .done               (done),
        .result             (result),
        .result_hi          (result_hi),
        .zero_flag          (zero_flag),
        .carry_flag         (carry_flag),
        .overflow_flag      (overflow_flag),
        .div_zero_flag      (div_zero_flag)
    );

    typedef struct {
        int unsigned res;
        int unsigned hi;
        bit          z, c, v, dz;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    // Architectural state as the bench believes it to be.
    int unsigned m_a = 0, m_b = 0, m_op = 0, m_res = 0;

    task automatic check(input string name, input longint act, input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic exp_t model(input int unsigned op, input int unsigned a, input int unsigned b);
        exp_t        e;
        int          sa, sb, s;
        int unsigned n, p;
        e  = '{default: 0};
        sa = (a >= 128) ? int'(a) - 256 : int'(a);
        sb = (b >= 128) ? int'(b) - 256 : int'(b);
        n  = b % W;
        case (op)
            0: begin
                p = a + b; e.res = p % 256; e.c = (p > 255);
                s = sa + sb; e.v = (s > 127) || (s < -128);
            end
            1: begin
                e.res = (a + 256 - b) % 256; e.c = (a < b);
                s = sa - sb; e.v = (s > 127) || (s < -128);
            end
            2: e.res = a & b;
            3: e.res = a | b;
            4: e.res = a ^ b;
            5: begin
                e.res = (a << n) % 256;
                e.c   = (n != 0) && (((a >> (W - n)) & 1) == 1);
            end
            6: begin
                e.res = a >> n;
                e.c   = (n != 0) && (((a >> (n - 1)) & 1) == 1);
            end
            7: begin
                p = a * b; e.res = p % 256; e.hi = p / 256; e.v = (e.hi != 0);
            end
            8: begin
                if (b == 0) begin
                    e.res = 255; e.hi = a; e.dz = 1;
                end else begin
                    e.res = a / b; e.hi = a % b;
                end
            end
            default: ;
        endcase
        e.z = (e.res == 0);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result",        result,        e.res);
                check("result_hi",     result_hi,     e.hi);
                check("zero_flag",     zero_flag,     e.z);
                check("carry_flag",    carry_flag,    e.c);
                check("overflow_flag", overflow_flag, e.v);
                check("div_zero_flag", div_zero_flag, e.dz);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a_val(input int unsigned v);
        user_input = v[W-1:0]; load_a = 1'b1;
        tick();
        load_a = 1'b0;
        m_a = v;
    endtask

    task automatic load_b_val(input int unsigned v);
        user_input = v[W-1:0]; load_b = 1'b1;
        tick();
        load_b = 1'b0;
        m_b = v;
    endtask

    task automatic load_ab(input int unsigned a, input int unsigned b);
        load_a_val(a);
        load_b_val(b);
    endtask

    task automatic load_from_res();
        load_a_from_result = 1'b1;
        tick();
        load_a_from_result = 1'b0;
        m_a = m_res;
    endtask

    task automatic set_op(input int unsigned op);
        user_opcode = op[3:0]; load_opcode = 1'b1;
        tick();
        load_opcode = 1'b0;
        m_op = op;
    endtask

    // Issue execute, wait (bounded) for done, check latency/busy/pulse width.
    // poke: drive load_a/execute during RUN, which must be ignored.
    // co_load: load A alongside execute; the op must still use the old A.
    task automatic run(input string tag, input bit poke, input bit co_load, input int unsigned co_val);
        exp_t e;
        int   cycles;
        bit   multi;
        e     = model(m_op, m_a, m_b);
        multi = (m_op == 7) || (m_op == 8 && m_b != 0);
        exp_q.push_back(e);
        execute = 1'b1;
        if (co_load) begin
            load_a = 1'b1; user_input = co_val[W-1:0];
        end
        tick();
        execute = 1'b0; load_a = 1'b0;
        if (co_load) m_a = co_val;
        cycles = 0;
        while (!done && cycles < 50) begin
            check({tag, "_busy_running"}, busy, multi);
            if (poke && (cycles == 2 || cycles == 4)) begin
                load_a = 1'b1; user_input = 8'hFF; execute = 1'b1;
            end
            tick();
            load_a = 1'b0; execute = 1'b0;
            cycles++;
        end
        check({tag, "_latency"}, cycles, multi ? W : 0);
        check({tag, "_busy_at_done"}, busy, 0);
        m_res = e.res;
        tick();
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dn;
        rst = 1'b1;
        tick(); tick();
        check("rst_result",    result,        0);
        check("rst_result_hi", result_hi,     0);
        check("rst_zero",      zero_flag,     0);
        check("rst_carry",     carry_flag,    0);
        check("rst_ovf",       overflow_flag, 0);
        check("rst_dz",        div_zero_flag, 0);
        check("rst_busy",      busy,          0);
        check("rst_done",      done,          0);
        rst = 1'b0;
        tick();

        load_ab(200, 100); set_op(0); run("add", 0, 0, 0);
        load_ab(5, 5);     set_op(1); run("sub_eq", 0, 0, 0);
        load_ab(3, 5);                run("sub_neg", 0, 0, 0);
        load_ab(8'h7F, 8'hFF);        run("sub_ovf", 0, 0, 0);
        load_ab(25, 20);   set_op(7); run("mul", 0, 0, 0);
        load_ab(100, 7);   set_op(8); run("div_poke", 1, 0, 0);
        set_op(0);                    run("after_poke", 0, 0, 0);
        load_ab(100, 0);   set_op(8); run("div0", 0, 0, 0);
        load_ab(1, 1);     set_op(0); run("add_clr_dz", 0, 0, 0);
        load_ab(8'h81, 9); set_op(5); run("shl_wrap", 0, 0, 0);
        load_ab(8'h81, 0);            run("shl_zero", 0, 0, 0);
        load_ab(8'h81, 7); set_op(6); run("shr7", 0, 0, 0);
        load_ab(8'h12, 8'h34); set_op(12); run("undef", 0, 0, 0);
        load_ab(10, 20);   set_op(0); run("co_load", 0, 1, 77);
        run("co_after", 0, 0, 0);

        // Reset during the third RUN cycle of a multiply: no done, all cleared.
        load_ab(9, 9); set_op(7);
        execute = 1'b1; tick(); execute = 1'b0;
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        m_a = 0; m_b = 0; m_op = 0; m_res = 0;
        check("mrst_result",    result,        0);
        check("mrst_result_hi", result_hi,     0);
        check("mrst_flags",     {zero_flag, carry_flag, overflow_flag, div_zero_flag}, 0);
        check("mrst_busy",      busy,          0);
        dn = 0;
        repeat (12) begin
            if (done) dn++;
            tick();
        end
        check("mrst_no_done", dn, 0);
        run("post_rst", 0, 0, 0);

        load_ab(6, 7); set_op(7); run("mul42", 0, 0, 0);
        load_from_res(); load_b_val(2); set_op(0); run("chain", 0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            int unsigned ra, rb, ro;
            ra = $urandom_range(0, 255);
            rb = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
            ro = $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) load_from_res();
            else                           load_a_val(ra);
            load_b_val(rb);
            set_op(ro);
            run("rand", 0, 0, 0);
        end

        tick(); tick();
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
